pwm_decoder: RTL and testbench

- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and recovers the generator's 2-bit frequency code and 4-bit duty code (0..10).
- Sits on the input pin side and drives status/decoded registers for downstream logic.
- Handles the generator's static outputs: constant low for duty 0 and constant high for duty 10.

---
 rtl/pwm_decoder.sv | 134 +++++++++++++
 tb/tb_pwm_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures an incoming PWM waveform and recovers its frequency and duty codes
module pwm_decoder #(
  parameter int CNT_W   = 8,
  parameter int TOL     = 1,
  parameter int TIMEOUT = 160
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pwm,
  output logic [1:0] o_freq,
  output logic [3:0] o_duty,
  output logic       o_valid,
  output logic       o_static,
  output logic       o_err,
  output logic       o_update
);
  typedef enum logic [1:0] {S_WAIT, S_MEAS, S_STATIC} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  logic             meta_q, s_q, sd_q;
  logic [CNT_W-1:0] p_cnt_q, p_cnt_d, h_cnt_q, h_cnt_d, h_q, h_d;
  logic             fall_seen_q, fall_seen_d;
  state_t           state_q, state_d;
  logic [1:0]       freq_q, freq_d;
  logic [3:0]       duty_q, duty_d;
  logic             valid_q, valid_d, stat_q, stat_d, err_q, err_d, update_q, update_d;
  logic             rise, fall, timeout, hit, good;
  logic [1:0]       f;
  logic [3:0]       duty_dec;
  int               dq;
  assign rise    = s_q & ~sd_q;
  assign fall    = ~s_q & sd_q;
  assign timeout = p_cnt_q == TO_VAL;
  assign o_freq   = freq_q;
  assign o_duty   = duty_q;
  assign o_valid  = valid_q;
  assign o_static = stat_q;
  assign o_err    = err_q;
  assign o_update = update_q;
  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
      sd_q   <= 1'b0;
    end else begin
      meta_q <= i_pwm;
      s_q    <= meta_q;
      sd_q   <= s_q;
    end
  end
  // Classify the measured period (lowest code wins) and round the high time to a duty code
  always_comb begin
    f   = 2'd0;
    hit = 1'b0;
    for (int c = 3; c >= 0; c--) begin
      if (int'(p_cnt_q) >= (80 >> c) - TOL && int'(p_cnt_q) <= (80 >> c) + TOL) begin
        hit = 1'b1;
        f   = 2'(c);
      end
    end
    dq       = (int'(h_q) + ((8 >> f) >> 1)) >> (3 - f);
    duty_dec = dq > 10 ? 4'd10 : 4'(dq);
    good     = hit && fall_seen_q && h_q <= p_cnt_q;
  end
  // Counters, high-time capture and state/output next values; a rise beats a coincident timeout
  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    duty_d      = duty_q;
    valid_d     = valid_q;
    stat_d      = stat_q;
    err_d       = err_q;
    update_d    = 1'b0;
    p_cnt_d     = rise ? CNT_ONE : (p_cnt_q == CNT_MAX ? p_cnt_q : p_cnt_q + CNT_ONE);
    h_cnt_d     = rise ? CNT_ONE : (s_q && h_cnt_q != CNT_MAX ? h_cnt_q + CNT_ONE : h_cnt_q);
    h_d         = fall ? h_cnt_q : h_q;
    fall_seen_d = rise ? 1'b0 : (fall ? 1'b1 : fall_seen_q);
    if (rise) begin
      state_d = S_MEAS;
      if (state_q == S_MEAS) begin
        update_d = 1'b1;
        err_d    = ~good;
        if (good) begin
          freq_d  = f;
          duty_d  = duty_dec;
          valid_d = 1'b1;
          stat_d  = 1'b0;
        end
      end
    end else if (fall && state_q == S_STATIC) begin
      state_d = S_WAIT;
      p_cnt_d = CNT_ONE;
      stat_d  = 1'b0;
      valid_d = 1'b0;
    end else if (timeout && state_q != S_STATIC) begin
      state_d  = S_STATIC;
      valid_d  = 1'b1;
      stat_d   = 1'b1;
      duty_d   = s_q ? 4'd10 : 4'd0;
      err_d    = 1'b0;
      update_d = 1'b1;
    end
  end
  // Measurement and decoded-output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_cnt_q     <= '0;
      h_cnt_q     <= '0;
      h_q         <= '0;
      fall_seen_q <= 1'b0;
      state_q     <= S_WAIT;
      freq_q      <= 2'd0;
      duty_q      <= 4'd0;
      valid_q     <= 1'b0;
      stat_q      <= 1'b0;
      err_q       <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      p_cnt_q     <= p_cnt_d;
      h_cnt_q     <= h_cnt_d;
      h_q         <= h_d;
      fall_seen_q <= fall_seen_d;
      state_q     <= state_d;
      freq_q      <= freq_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      stat_q      <= stat_d;
      err_q       <= err_d;
      update_q    <= update_d;
    end
  end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed self-checking bench for pwm_decoder
module tb_pwm_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm = 1'b0;
  logic [1:0] freq, freq2;
  logic [3:0] duty, duty2;
  logic       valid, stat, err, upd, valid2, stat2, err2, upd2;
  int         n = 0;
  int         fails = 0;
  int         upd_cnt = 0;
  int         base = 0;
  pwm_decoder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pwm(pwm),
    .o_freq(freq), .o_duty(duty), .o_valid(valid),
    .o_static(stat), .o_err(err), .o_update(upd)
  );
  pwm_decoder #(.TIMEOUT(80)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pwm(pwm),
    .o_freq(freq2), .o_duty(duty2), .o_valid(valid2),
    .o_static(stat2), .o_err(err2), .o_update(upd2)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (upd) upd_cnt++;
  task automatic chk(input string tag, input int obs, input int exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic period(input int p, input int h);
    pwm = 1'b1;
    repeat (h) @(negedge clk);
    pwm = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_freq", freq, 0);
    chk("rst_duty", duty, 0);
    chk("rst_valid", valid, 0);
    chk("rst_static", stat, 0);
    chk("rst_err", err, 0);
    chk("rst_update", upd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      period(80, 24);
      chk("p80_updates", upd_cnt, i - 1);
      if (i > 1) begin
        chk("p80_freq", freq, 0);
        chk("p80_duty", duty, 3);
        chk("p80_valid", valid, 1);
        chk("p80_err", err, 0);
        chk("to80_static", stat2, 0);
        chk("to80_freq", freq2, 0);
        chk("to80_valid", valid2, 1);
      end
    end
    for (int h = 1; h <= 9; h++) begin
      period(10, h);
      if (h > 1) begin
        chk("p10_freq", freq, 3);
        chk("p10_duty", duty, h - 1);
      end
    end
    period(10, 5);
    chk("p10_freq9", freq, 3);
    chk("p10_duty9", duty, 9);
    base = upd_cnt;
    repeat (170) @(negedge clk);
    chk("lo_static", stat, 1);
    chk("lo_valid", valid, 1);
    chk("lo_duty", duty, 0);
    chk("lo_err", err, 0);
    chk("lo_freq", freq, 3);
    chk("lo_updates", upd_cnt - base, 1);
    base = upd_cnt;
    pwm = 1'b1;
    repeat (180) @(negedge clk);
    chk("hi_static", stat, 1);
    chk("hi_duty", duty, 10);
    chk("hi_updates", upd_cnt - base, 1);
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    chk("hifall_static", stat, 0);
    chk("hifall_valid", valid, 0);
    chk("hifall_updates", upd_cnt - base, 1);
    base = upd_cnt;
    period(41, 21);
    chk("p41_first", upd_cnt - base, 0);
    period(60, 30);
    chk("p41_freq", freq, 1);
    chk("p41_duty", duty, 5);
    chk("p41_err", err, 0);
    chk("p41_updates", upd_cnt - base, 1);
    period(20, 8);
    chk("p60_err", err, 1);
    chk("p60_freq", freq, 1);
    chk("p60_duty", duty, 5);
    chk("p60_valid", valid, 1);
    chk("p60_updates", upd_cnt - base, 2);
    period(20, 8);
    chk("p20_err", err, 0);
    chk("p20_freq", freq, 2);
    chk("p20_duty", duty, 4);
    base = upd_cnt;
    pwm = 1'b1;
    repeat (200) @(negedge clk);
    chk("sh_static", stat, 1);
    chk("sh_duty", duty, 10);
    chk("sh_valid", valid, 1);
    chk("sh_freq", freq, 2);
    chk("sh_err", err, 0);
    chk("sh_updates", upd_cnt - base, 2);
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    chk("shfall_valid", valid, 0);
    chk("shfall_static", stat, 0);
    chk("shfall_updates", upd_cnt - base, 2);
    period(40, 12);
    chk("p40_first", upd_cnt - base, 2);
    period(40, 12);
    chk("p40_freq", freq, 1);
    chk("p40_duty", duty, 3);
    chk("p40_valid", valid, 1);
    chk("p40_updates", upd_cnt - base, 3);
    period(20, 10);
    period(20, 10);
    chk("pre_rst_freq", freq, 2);
    chk("pre_rst_duty", duty, 5);
    pwm = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_freq", freq, 0);
    chk("arst_duty", duty, 0);
    chk("arst_valid", valid, 0);
    chk("arst_static", stat, 0);
    chk("arst_err", err, 0);
    chk("arst_update", upd, 0);
    pwm = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = upd_cnt;
    period(20, 10);
    chk("post_rst_first", upd_cnt - base, 0);
    chk("post_rst_valid", valid, 0);
    period(20, 10);
    chk("post_rst_updates", upd_cnt - base, 1);
    chk("post_rst_freq", freq, 2);
    chk("post_rst_duty", duty, 5);
    chk("post_rst_valid2", valid, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
